core_id_stage_pipe: RTL and testbench

- Pipelined decode stage: instruction field decode, main control, immediate generation, register file with write-through bypass, load-use hazard detection, and the ID/EX pipeline register.
- Sits between the IF stage (valid/stall handshake) and the EX stage (registered outputs, flush input).
- Generalises the combinational decode stage with configurable XLEN and register count (RV32E/RV32I), illegal-instruction flagging, stall and flush.

---
 rtl/core_id_stage_pipe_if.sv | 45 ++++
 rtl/core_id_stage_pipe.sv | 185 ++++++++++++++++++
 tb/tb_core_id_stage_pipe.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/core_id_stage_pipe_if.sv
// rtl/core_id_stage_pipe_if.sv - IF/WB-to-ID inputs and ID/EX register outputs of the decode stage
interface core_id_stage_pipe_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic [XLEN-1:0] i_instr;
  logic [XLEN-1:0] i_pc;
  logic            i_flush;
  logic [4:0]      i_wb_rd;
  logic            i_wb_reg_write;
  logic [XLEN-1:0] i_rd_din;
  logic            o_stall;
  logic            o_valid;
  logic [XLEN-1:0] o_pc;
  logic [6:0]      o_opcode;
  logic [4:0]      o_rd;
  logic [2:0]      o_funct3;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [6:0]      o_funct7;
  logic            o_mem_read;
  logic            o_mem_write;
  logic            o_reg_write;
  logic [1:0]      o_mem_to_reg;
  logic [1:0]      o_d_size;
  logic            o_d_unsigned;
  logic [XLEN-1:0] o_imm;
  logic [XLEN-1:0] o_rs1_dout;
  logic [XLEN-1:0] o_rs2_dout;
  logic            o_illegal;

  modport master (
    output i_valid, i_instr, i_pc, i_flush, i_wb_rd, i_wb_reg_write, i_rd_din,
    input  o_stall, o_valid, o_pc, o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7,
           o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_d_size, o_d_unsigned,
           o_imm, o_rs1_dout, o_rs2_dout, o_illegal
  );

  modport slave (
    input  i_valid, i_instr, i_pc, i_flush, i_wb_rd, i_wb_reg_write, i_rd_din,
    output o_stall, o_valid, o_pc, o_opcode, o_rd, o_funct3, o_rs1, o_rs2, o_funct7,
           o_mem_read, o_mem_write, o_reg_write, o_mem_to_reg, o_d_size, o_d_unsigned,
           o_imm, o_rs1_dout, o_rs2_dout, o_illegal
  );
endinterface

// File: rtl/core_id_stage_pipe.sv
// rtl/core_id_stage_pipe.sv - pipelined decode stage with regfile bypass, load-use stall and ID/EX register
module core_id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input logic                i_clk,
  input logic                i_rst,
  core_id_stage_pipe_if.slave bus
);
  localparam int         AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  assign ins    = bus.i_instr[31:0];
  assign opcode = ins[6:0];
  assign rd     = ins[11:7];
  assign funct3 = ins[14:12];
  assign rs1    = ins[19:15];
  assign rs2    = ins[24:20];
  assign funct7 = ins[31:25];

  logic            known, rs1_used, rs2_used, rd_used;
  logic            dec_rw, dec_mr, dec_mw, dec_duns, illegal;
  logic [1:0]      dec_mtr, dec_dsize;
  logic [XLEN-1:0] dec_imm;

  // Main control, format selection and sign-extended immediate
  always_comb begin
    known     = 1'b1;
    rs1_used  = 1'b0;
    rs2_used  = 1'b0;
    rd_used   = 1'b0;
    dec_rw    = 1'b0;
    dec_mr    = 1'b0;
    dec_mw    = 1'b0;
    dec_mtr   = 2'b00;
    dec_dsize = 2'b00;
    dec_duns  = 1'b0;
    dec_imm   = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        rd_used = 1'b1;
        dec_rw  = 1'b1;
        dec_imm = XLEN'($signed({ins[31:12], 12'b0}));
      end
      OP_JAL: begin
        rd_used = 1'b1;
        dec_rw  = 1'b1;
        dec_mtr = 2'b10;
        dec_imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      OP_JALR: begin
        rs1_used = 1'b1;
        rd_used  = 1'b1;
        dec_rw   = 1'b1;
        dec_mtr  = 2'b10;
        dec_imm  = XLEN'($signed(ins[31:20]));
      end
      OP_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        dec_imm  = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      OP_LOAD: begin
        rs1_used  = 1'b1;
        rd_used   = 1'b1;
        dec_rw    = 1'b1;
        dec_mr    = 1'b1;
        dec_mtr   = 2'b01;
        dec_dsize = funct3[1:0];
        dec_duns  = funct3[2];
        dec_imm   = XLEN'($signed(ins[31:20]));
      end
      OP_STORE: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        dec_mw    = 1'b1;
        dec_dsize = funct3[1:0];
        dec_imm   = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      OP_IMM: begin
        rs1_used = 1'b1;
        rd_used  = 1'b1;
        dec_rw   = 1'b1;
        dec_imm  = XLEN'($signed(ins[31:20]));
      end
      OP_OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        rd_used  = 1'b1;
        dec_rw   = 1'b1;
      end
      default: known = 1'b0;
    endcase
    illegal = ~known
            | (rs1_used & ({1'b0, rs1} >= NR))
            | (rs2_used & ({1'b0, rs2} >= NR))
            | (rd_used  & ({1'b0, rd}  >= NR));
  end

  // Register file; out-of-range indices never write and read as zero
  logic [XLEN-1:0] rf [NUM_REGS];
  logic            wb_we;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign wb_we   = bus.i_wb_reg_write & (bus.i_wb_rd != 5'd0) & ({1'b0, bus.i_wb_rd} < NR);
  assign rs1_val = (rs1 == 5'd0 || {1'b0, rs1} >= NR) ? '0 :
                   (wb_we && bus.i_wb_rd == rs1) ? bus.i_rd_din : rf[rs1[AW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || {1'b0, rs2} >= NR) ? '0 :
                   (wb_we && bus.i_wb_rd == rs2) ? bus.i_rd_din : rf[rs2[AW-1:0]];

  // Writeback port, independent of stall and flush
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[bus.i_wb_rd[AW-1:0]] <= bus.i_rd_din;
    end
  end

  // Load-use hazard against the load sitting in ID/EX; flush releases it
  logic issue;
  assign bus.o_stall = bus.i_valid & bus.o_valid & bus.o_mem_read & (bus.o_rd != 5'd0)
                     & ((rs1_used & (rs1 == bus.o_rd)) | (rs2_used & (rs2 == bus.o_rd)))
                     & ~bus.i_flush;
  assign issue = bus.i_valid & ~bus.i_flush & ~bus.o_stall;

  // ID/EX register: fields and data always load, control only when issuing
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bus.o_valid      <= 1'b0;
      bus.o_pc         <= '0;
      bus.o_opcode     <= '0;
      bus.o_rd         <= '0;
      bus.o_funct3     <= '0;
      bus.o_rs1        <= '0;
      bus.o_rs2        <= '0;
      bus.o_funct7     <= '0;
      bus.o_mem_read   <= 1'b0;
      bus.o_mem_write  <= 1'b0;
      bus.o_reg_write  <= 1'b0;
      bus.o_mem_to_reg <= '0;
      bus.o_d_size     <= '0;
      bus.o_d_unsigned <= 1'b0;
      bus.o_imm        <= '0;
      bus.o_rs1_dout   <= '0;
      bus.o_rs2_dout   <= '0;
      bus.o_illegal    <= 1'b0;
    end else begin
      bus.o_valid      <= issue;
      bus.o_pc         <= bus.i_pc;
      bus.o_opcode     <= opcode;
      bus.o_rd         <= rd;
      bus.o_funct3     <= funct3;
      bus.o_rs1        <= rs1;
      bus.o_rs2        <= rs2;
      bus.o_funct7     <= funct7;
      bus.o_imm        <= dec_imm;
      bus.o_rs1_dout   <= rs1_val;
      bus.o_rs2_dout   <= rs2_val;
      bus.o_mem_read   <= issue & dec_mr & ~illegal;
      bus.o_mem_write  <= issue & dec_mw & ~illegal;
      bus.o_reg_write  <= issue & dec_rw & ~illegal;
      bus.o_mem_to_reg <= issue ? dec_mtr : 2'b00;
      bus.o_d_size     <= issue ? dec_dsize : 2'b00;
      bus.o_d_unsigned <= issue & dec_duns;
      bus.o_illegal    <= issue & illegal;
    end
  end
endmodule

// File: tb/tb_core_id_stage_pipe.sv
// tb/tb_core_id_stage_pipe.sv - directed vector bench for the decode stage (RV32I and RV32E instances)
module tb_core_id_stage_pipe;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  core_id_stage_pipe_if #(.XLEN(32)) bus ();
  core_id_stage_pipe_if #(.XLEN(32)) ebus ();

  core_id_stage_pipe #(.XLEN(32), .NUM_REGS(32)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  core_id_stage_pipe #(.XLEN(32), .NUM_REGS(16)) dut_e (.i_clk(clk), .i_rst(rst), .bus(ebus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [1:0]  mtr;
    logic [1:0]  dsize;
    logic        duns;
    logic        ill;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{32'hFFF00093, 32'h100, 5'd1,  32'hFFFFFFFF, 1, 0, 0, 2'b00, 2'd0, 0, 0};
    vecs[1] = '{32'h123452B7, 32'h104, 5'd5,  32'h12345000, 1, 0, 0, 2'b00, 2'd0, 0, 0};
    vecs[2] = '{32'h0020A423, 32'h108, 5'd8,  32'h00000008, 0, 0, 1, 2'b00, 2'd2, 0, 0};
    vecs[3] = '{32'hFE208EE3, 32'h10C, 5'd29, 32'hFFFFFFFC, 0, 0, 0, 2'b00, 2'd0, 0, 0};
    vecs[4] = '{32'h001000EF, 32'h110, 5'd1,  32'h00000800, 1, 0, 0, 2'b10, 2'd0, 0, 0};
    vecs[5] = '{32'hFFF3C303, 32'h114, 5'd6,  32'hFFFFFFFF, 1, 1, 0, 2'b01, 2'd0, 1, 0};
    vecs[6] = '{32'h0000000B, 32'h118, 5'd0,  32'h00000000, 0, 0, 0, 2'b00, 2'd0, 0, 1};
    vecs[7] = '{32'hFFFFF517, 32'h11C, 5'd10, 32'hFFFFF000, 1, 0, 0, 2'b00, 2'd0, 0, 0};
    vecs[8] = '{32'h00408067, 32'h120, 5'd0,  32'h00000004, 1, 0, 0, 2'b10, 2'd0, 0, 0};
    vecs[9] = '{32'h00318233, 32'h124, 5'd4,  32'h00000000, 1, 0, 0, 2'b00, 2'd0, 0, 0};

    bus.i_valid = 0; bus.i_instr = 0; bus.i_pc = 0; bus.i_flush = 0;
    bus.i_wb_rd = 0; bus.i_wb_reg_write = 0; bus.i_rd_din = 0;
    ebus.i_valid = 0; ebus.i_instr = 0; ebus.i_pc = 0; ebus.i_flush = 0;
    ebus.i_wb_rd = 0; ebus.i_wb_reg_write = 0; ebus.i_rd_din = 0;
    rst = 1;
    #12;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_stall", bus.o_stall, 0);
    chk("rst_imm", bus.o_imm, 0);
    @(negedge clk);
    rst = 0;

    // Single-instruction decode table
    for (int i = 0; i < 10; i++) begin
      bus.i_valid = 1;
      bus.i_instr = vecs[i].instr;
      bus.i_pc    = vecs[i].pc;
      tick();
      chk($sformatf("v%0d_valid", i), bus.o_valid, 1);
      chk($sformatf("v%0d_pc", i), bus.o_pc, vecs[i].pc);
      chk($sformatf("v%0d_opcode", i), bus.o_opcode, vecs[i].instr[6:0]);
      chk($sformatf("v%0d_rd", i), bus.o_rd, vecs[i].rd);
      chk($sformatf("v%0d_imm", i), bus.o_imm, vecs[i].imm);
      chk($sformatf("v%0d_rw", i), bus.o_reg_write, vecs[i].rw);
      chk($sformatf("v%0d_mr", i), bus.o_mem_read, vecs[i].mr);
      chk($sformatf("v%0d_mw", i), bus.o_mem_write, vecs[i].mw);
      chk($sformatf("v%0d_mtr", i), bus.o_mem_to_reg, vecs[i].mtr);
      chk($sformatf("v%0d_dsize", i), bus.o_d_size, vecs[i].dsize);
      chk($sformatf("v%0d_duns", i), bus.o_d_unsigned, vecs[i].duns);
      chk($sformatf("v%0d_ill", i), bus.o_illegal, vecs[i].ill);
    end

    // Write-through bypass: x3 written while add x4,x3,x3 decodes
    bus.i_instr = 32'h00318233;
    bus.i_wb_rd = 5'd3; bus.i_wb_reg_write = 1; bus.i_rd_din = 32'h1234;
    tick();
    chk("byp_rs1", bus.o_rs1_dout, 32'h1234);
    chk("byp_rs2", bus.o_rs2_dout, 32'h1234);
    bus.i_wb_reg_write = 0;
    bus.i_instr = 32'h00018233;
    tick();
    chk("rf_rs1", bus.o_rs1_dout, 32'h1234);
    chk("rf_rs2_x0", bus.o_rs2_dout, 0);

    // Load-use: lw x2,0(x1) then add x3,x2,x1
    bus.i_instr = 32'h0000A103;
    tick();
    chk("lu_load_mr", bus.o_mem_read, 1);
    bus.i_instr = 32'h001101B3;
    #1;
    chk("lu_stall", bus.o_stall, 1);
    tick();
    chk("lu_bubble_valid", bus.o_valid, 0);
    chk("lu_bubble_rw", bus.o_reg_write, 0);
    chk("lu_stall_released", bus.o_stall, 0);
    tick();
    chk("lu_add_valid", bus.o_valid, 1);
    chk("lu_add_rd", bus.o_rd, 3);
    chk("lu_add_stall", bus.o_stall, 0);

    // Flush during the stall cycle
    bus.i_instr = 32'h0000A103;
    tick();
    bus.i_instr = 32'h001101B3;
    bus.i_flush = 1;
    #1;
    chk("fl_stall", bus.o_stall, 0);
    tick();
    chk("fl_valid", bus.o_valid, 0);
    chk("fl_mr", bus.o_mem_read, 0);
    bus.i_flush = 0;
    bus.i_valid = 0;

    // Async reset mid-stream clears outputs and the register file
    bus.i_wb_rd = 5'd5; bus.i_wb_reg_write = 1; bus.i_rd_din = 32'hABCD;
    tick();
    bus.i_wb_reg_write = 0;
    bus.i_valid = 1;
    bus.i_instr = 32'h00028333;
    bus.i_pc = 32'h200;
    tick();
    chk("x5_written", bus.o_rs1_dout, 32'hABCD);
    chk("pre_rst_valid", bus.o_valid, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_rw", bus.o_reg_write, 0);
    chk("arst_pc", bus.o_pc, 0);
    chk("arst_rs1", bus.o_rs1_dout, 0);
    chk("arst_stall", bus.o_stall, 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("post_rst_valid", bus.o_valid, 1);
    chk("post_rst_x5", bus.o_rs1_dout, 0);
    bus.i_valid = 0;

    // RV32E: out-of-range rd and ignored writeback to x20
    ebus.i_valid = 1;
    ebus.i_instr = 32'h002088B3;
    tick();
    chk("e_valid", ebus.o_valid, 1);
    chk("e_illegal", ebus.o_illegal, 1);
    chk("e_rw", ebus.o_reg_write, 0);
    ebus.i_valid = 0;
    ebus.i_wb_rd = 5'd20; ebus.i_wb_reg_write = 1; ebus.i_rd_din = 32'hDEAD;
    tick();
    ebus.i_wb_reg_write = 0;
    ebus.i_valid = 1;
    ebus.i_instr = 32'h000202B3;
    tick();
    chk("e_x4_untouched", ebus.o_rs1_dout, 0);
    chk("e_legal", ebus.o_illegal, 0);
    chk("e_legal_rw", ebus.o_reg_write, 1);
    ebus.i_valid = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
